mem_read_responder: RTL

MEM_READ_RESPONDER -- requirements
Module: mem_read_responder

---
 rtl/mem_read_responder_pkg.sv | 27 ++
 rtl/mem_ram.sv | 38 +++
 rtl/mem_read_responder.sv | 103 ++++++++++
 3 files changed

// File: rtl/mem_read_responder_pkg.sv
// Shared CPU definitions: data word width, read-responder FSM encodings and opcode constants.
// Imported by the read responder and its RAM.
package mem_read_responder_pkg;

  localparam int WORD_W = 16;
  localparam int CNT_W  = 4;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_WAIT   = 2'b01,
    ST_DATA   = 2'b10,
    ST_FINISH = 2'b11
  } rd_state_e;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_JMP   = 4'h4;

  function automatic logic state_is_busy(input rd_state_e s);
    return s != ST_IDLE;
  endfunction

endpackage

// File: rtl/mem_ram.sv
// Word RAM: one synchronous write port and one registered read port.
// A read and a write to the same address in one cycle return the old word.
module mem_ram
  import mem_read_responder_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  word_t             wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output word_t             rdata
);

  word_t mem [2**ADDR_W];
  word_t rdata_q, rdata_d;

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_read_responder.sv
// Memory read responder: accepts a held read request, waits WAIT_CYCLES, then returns
// one word with a valid pulse followed by a finish pulse.
module mem_read_responder
  import mem_read_responder_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_mem_req,
  input  logic [15:0] read_addr,
  output logic        read_mem_valid,
  output logic        read_mem_finish,
  output logic [15:0] out_mem_data,
  output logic        busy,
  input  logic        wr_en,
  input  logic [15:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic [1:0]  dbg_state
);

  // Handshake: the requester holds read_mem_req until it sees read_mem_valid; valid marks
  // the single cycle out_mem_data carries the word, and finish follows in the next cycle.

  rd_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  word_t             ram_rdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rd_en   = 1'b0;
    rd_addr = addr_q;
    case (state_q)
      ST_IDLE: begin
        // With no wait states the address is not latched yet, so read straight from the port.
        rd_addr = read_addr[ADDR_W-1:0];
        if (read_mem_req) begin
          addr_d = read_addr[ADDR_W-1:0];
          if (WAIT_CYCLES == 0) begin
            cnt_d   = '0;
            state_d = ST_DATA;
            rd_en   = 1'b1;
          end else begin
            cnt_d   = CNT_W'(WAIT_CYCLES);
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_DATA;
          rd_en   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DATA:   state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  mem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (wr_addr[ADDR_W-1:0]),
    .wdata (wr_data),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

  assign read_mem_valid  = (state_q == ST_DATA);
  assign read_mem_finish = (state_q == ST_FINISH);
  assign busy            = state_is_busy(state_q);
  assign out_mem_data    = ram_rdata;
  assign dbg_state       = state_q;

  // Upper address bits wrap away on both paths.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{read_addr[15:ADDR_W], wr_addr[15:ADDR_W]};

endmodule
